// File: rtl/prog_loader.sv
// Framed byte-stream loader for the uP program memory.
// Header length, payload writes, checksum gate on core release.
module prog_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LEN_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              rst_hold_q;

  logic       xfer;
  logic       hi_bad;
  logic [7:0] sum_nx;

  assign xfer   = in_valid & in_ready;
  assign sum_nx = sum_q + in_data;
  // Header bits that would exceed the address space
  assign hi_bad = |(in_data >> (ADDR_W - 8));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          len_d   = '0;
          count_d = '0;
          sum_d   = '0;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          sum_d              = sum_nx;
          len_d[ADDR_W-1:8]  = in_data[ADDR_W-9:0];
          state_d            = hi_bad ? S_ERR : S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          sum_d      = sum_nx;
          len_d[7:0] = in_data;
          state_d    = (len_d == '0) ? S_CHECK : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d       = sum_nx;
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q;
          mem_wdata_d = in_data;
          count_d     = count_q + LEN_ONE;
          if (count_q == len_q - LEN_ONE) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (sum_nx == 8'h00) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rst_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rst_hold_q  <= 1'b0;
    end
  end

  assign busy      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
  assign in_ready  = busy;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  // Core stays held through reset and the cycle right after it
  assign cpu_reset = reset | rst_hold_q |
                     ~((state_q == S_IDLE) || (state_q == S_DONE));
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: vector table plus
// hand sequences for header, zero length, stalls, reset.
module tb_prog_loader;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  prog_loader #(.ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          st;
    logic          vld;
    logic [7:0]    dat;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wd;
    logic          cpu;
    logic          bsy;
    logic          dn;
    logic          er;
  } vec_t;

  vec_t tbl [19];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [19:0] wr_q [$];
  logic [7:0]  good [6];
  logic [19:0] exp_wr [3];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [7:0] d);
    reset    = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic check_writes(input string nm, input int n);
    chk({nm, "_wr_cnt"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++)
      chk({nm, "_wr"}, {12'h0, wr_q[i]}, {12'h0, exp_wr[i]});
  endtask

  task automatic good_load(input string nm, input int gap);
    wr_q.delete();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send(good[i], gap);
    chk({nm, "_done"}, {29'h0, done, error, cpu_reset}, 32'h4);
    check_writes(nm, 3);
  endtask

  initial begin
    logic [25:0] got, exp;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    good   = '{8'h00, 8'h03, 8'hA5, 8'h3C, 8'h01, 8'h1B};
    exp_wr = '{{12'h000, 8'hA5}, {12'h001, 8'h3C}, {12'h002, 8'h01}};

    // rst st vld dat | rdy we addr wd cpu bsy dn er
    tbl[0]  = '{1, 1, 1, 8'h55, 0, 0, 12'h0, 8'h00, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 12'h0, 8'h00, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 8'hFF, 0, 0, 12'h0, 8'h00, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 8'h00, 1, 0, 12'h0, 8'h00, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 8'h00, 1, 0, 12'h0, 8'h00, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 8'h03, 1, 0, 12'h0, 8'h00, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 8'hA5, 1, 1, 12'h0, 8'hA5, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 8'h3C, 1, 1, 12'h1, 8'h3C, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 8'h01, 1, 1, 12'h2, 8'h01, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 8'h1B, 0, 0, 12'h2, 8'h01, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 0, 12'h2, 8'h01, 0, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 8'h00, 1, 0, 12'h2, 8'h01, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 8'h00, 1, 0, 12'h2, 8'h01, 1, 1, 0, 0};
    tbl[13] = '{0, 0, 1, 8'h03, 1, 0, 12'h2, 8'h01, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 1, 8'hA5, 1, 1, 12'h0, 8'hA5, 1, 1, 0, 0};
    tbl[15] = '{0, 0, 1, 8'h3C, 1, 1, 12'h1, 8'h3C, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 1, 8'h01, 1, 1, 12'h2, 8'h01, 1, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 8'h1C, 0, 0, 12'h2, 8'h01, 1, 0, 0, 1};
    tbl[18] = '{0, 1, 1, 8'h00, 1, 0, 12'h2, 8'h01, 1, 1, 0, 0};

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].vld, tbl[i].dat);
      got = {in_ready, mem_we, mem_addr, mem_wdata,
             cpu_reset, busy, done, error};
      exp = {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd,
             tbl[i].cpu, tbl[i].bsy, tbl[i].dn, tbl[i].er};
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL vec%0d: got %07h expected %07h", i, got, exp);
    end

    // back to idle, then bad header
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    wr_q.delete();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h10);
    chk("badhdr_err", {28'h0, error, in_ready, busy, cpu_reset}, 32'h9);
    cyc(1'b0, 1'b0, 1'b1, 8'h03);
    chk("badhdr_hold", {30'h0, error, in_ready}, 32'h2);
    chk("badhdr_nowr", wr_q.size(), 0);
    good_load("after_bad", 0);

    // zero length
    wr_q.delete();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_done", {29'h0, done, error, cpu_reset}, 32'h4);
    chk("zero_nowr", wr_q.size(), 0);

    good_load("stall", 3);

    // reset after the second data byte
    wr_q.delete();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h00, 0);
    send(8'h03, 0);
    send(8'hA5, 0);
    send(8'h3C, 0);
    cyc(1'b1, 1'b0, 1'b1, 8'h01);
    chk("midrst_hold", {28'h0, cpu_reset, busy, in_ready, mem_we}, 32'h8);
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    chk("midrst_rel", {28'h0, cpu_reset, busy, in_ready, done}, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h1B);
    check_writes("midrst", 2);
    good_load("after_rst", 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
